temp_qsys_nios2_gen2_cpu_mul_combine: RTL

TEMP_QSYS_NIOS2_GEN2_CPU_MUL_COMBINE -- requirements
Module: temp_qsys_nios2_gen2_cpu_mul_combine

---
 rtl/temp_qsys_mul_pkg.sv | 27 ++
 rtl/temp_qsys_mul_hi_iter.sv | 70 +++++++
 rtl/temp_qsys_nios2_gen2_cpu_mul_combine.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/temp_qsys_mul_pkg.sv
// Shared types and constants for the Nios II multiply-combine block.
// The FSM state HI_MUL exists only when TEMP_QSYS_MUL_COMBINE_MULX_EN is defined.
package temp_qsys_mul_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;
  localparam int MID_W  = 33;

  // Default multiplier bits retired per cycle and the matching iteration count.
  localparam int HI_ITER_BITS_DEF = 2;
  localparam int HI_ITERS         = HALF_W / HI_ITER_BITS_DEF;

  // Iteration count for a given number of bits retired per cycle.
  function automatic int hi_iters(input int iter_bits);
    return HALF_W / iter_bits;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SUM    = 2'd1,
`ifdef TEMP_QSYS_MUL_COMBINE_MULX_EN
    ST_HI_MUL = 2'd2,
`endif
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/temp_qsys_mul_hi_iter.sv
// Iterative 16x16 unsigned shift-add multiplier, ITER_BITS multiplier bits per cycle.
// start_i loads the operands; done_o is high during the final iteration cycle,
// when prod_o already shows the complete product.
module temp_qsys_mul_hi_iter
  import temp_qsys_mul_pkg::*;
#(
  parameter int ITER_BITS = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_i,
  input  logic [HALF_W-1:0]   a_i,
  input  logic [HALF_W-1:0]   b_i,
  output logic                done_o,
  output logic [WORD_W-1:0]   prod_o
);

  localparam int ITERS = hi_iters(ITER_BITS);
  localparam int CNT_W = $clog2(ITERS + 1);

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] mcand_q, mcand_d;
  logic [HALF_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] partial;

  // Partial product of this step and next state of the shift-add datapath.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
    partial  = '0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    for (int j = 0; j < ITER_BITS; j++) begin
      if (mplier_q[j]) partial = partial + (mcand_q << j);
    end
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = {{(WORD_W-HALF_W){1'b0}}, a_i};
      mplier_d = b_i;
      cnt_d    = CNT_W'(ITERS);
    end else if (cnt_q != '0) begin
      acc_d    = acc_q + partial;
      mcand_d  = mcand_q << ITER_BITS;
      mplier_d = mplier_q >> ITER_BITS;
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  // Datapath and iteration counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CNT_W'(1));
  assign prod_o = acc_q + partial;

endmodule

// File: rtl/temp_qsys_nios2_gen2_cpu_mul_combine.sv
// Combines three 16x16 partial products into the low word of a 32x32 product.
// With TEMP_QSYS_MUL_COMBINE_MULX_EN defined, op_hi instead returns the high word,
// using an iterative multiplier for src1_hi*src2_hi.
module temp_qsys_nios2_gen2_cpu_mul_combine
  import temp_qsys_mul_pkg::*;
#(
  parameter int HI_ITER_BITS = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] p1,
  input  logic [31:0] p2,
  input  logic [31:0] p3,
  input  logic [15:0] src1_hi,
  input  logic [15:0] src2_hi,
  input  logic        op_hi,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic [WORD_W-1:0] result_q, result_d;
  logic [MID_W-1:0]  mid;
  logic [HALF_W:0]   s;
  logic [WORD_W-1:0] low_word;

  // Column sums: the two cross products, then their low half added onto p1's upper half.
  always_comb begin
    mid      = {1'b0, p2_q} + {1'b0, p3_q};
    s        = {1'b0, p1_q[31:16]} + {1'b0, mid[15:0]};
    low_word = {s[15:0], p1_q[15:0]};
  end

`ifdef TEMP_QSYS_MUL_COMBINE_MULX_EN
  logic [HALF_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic              op_hi_q, op_hi_d;
  logic              hi_start, hi_done;
  logic [WORD_W-1:0] hi_prod;

  assign hi_start = (state_q == ST_SUM) && op_hi_q;

  temp_qsys_mul_hi_iter #(
    .ITER_BITS (HI_ITER_BITS)
  ) u_hi_iter (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (hi_start),
    .a_i     (s1_q),
    .b_i     (s2_q),
    .done_o  (hi_done),
    .prod_o  (hi_prod)
  );
`else
  logic unused_hi;
  assign unused_hi = ^{src1_hi, src2_hi, op_hi, mid[32:16]};
`endif

  // Next-state, capture and result-load logic of the control FSM.
  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    p3_d     = p3_q;
    result_d = result_q;
`ifdef TEMP_QSYS_MUL_COMBINE_MULX_EN
    s1_d     = s1_q;
    s2_d     = s2_q;
    op_hi_d  = op_hi_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          p1_d    = p1;
          p2_d    = p2;
          p3_d    = p3;
`ifdef TEMP_QSYS_MUL_COMBINE_MULX_EN
          s1_d    = src1_hi;
          s2_d    = src2_hi;
          op_hi_d = op_hi;
`endif
          state_d = ST_SUM;
        end
      end
      ST_SUM: begin
`ifdef TEMP_QSYS_MUL_COMBINE_MULX_EN
        if (op_hi_q) begin
          state_d = ST_HI_MUL;
        end else begin
          result_d = low_word;
          state_d  = ST_DONE;
        end
`else
        result_d = low_word;
        state_d  = ST_DONE;
`endif
      end
`ifdef TEMP_QSYS_MUL_COMBINE_MULX_EN
      ST_HI_MUL: begin
        if (hi_done) begin
          result_d = hi_prod + {15'b0, mid[32:16]} + {31'b0, s[16]};
          state_d  = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured operands and held result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      p1_q     <= '0;
      p2_q     <= '0;
      p3_q     <= '0;
      result_q <= '0;
`ifdef TEMP_QSYS_MUL_COMBINE_MULX_EN
      s1_q     <= '0;
      s2_q     <= '0;
      op_hi_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      p3_q     <= p3_d;
      result_q <= result_d;
`ifdef TEMP_QSYS_MUL_COMBINE_MULX_EN
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      op_hi_q  <= op_hi_d;
`endif
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = result_q;

endmodule
